// File: rtl/sram_axi_pkg.sv
// Shared types for the SRAM-to-AXI bridge: write FSM states, size codes, counter sizing.
// Imported by sram_axi_bridge and its testbench.
package sram_axi_pkg;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_SEND   = 2'd1,
        WR_WAIT_B = 2'd2
    } wr_state_e;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/bridge_arbiter.sv
// One-hot grant from the eligible vector, combinational (0 cycles); no backpressure of its own.
// BRIDGE_RR_ARB_EN: round-robin from last grant + 1; otherwise highest index wins.
module bridge_arbiter #(
    parameter int CH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CH-1:0] elig_i,
    output logic [CH-1:0] grant_o
);

`ifdef BRIDGE_RR_ARB_EN
    localparam int PW = (CH > 1) ? $clog2(CH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        ptr_d   = ptr_q;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(ptr_q) + k) % CH;
            if (grant_o == '0 && elig_i[idx]) begin
                grant_o[idx] = 1'b1;
                ptr_d        = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < CH; i++) begin
            if (elig_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sram_axi_bridge.sv
// Split-handshake SRAM channels onto one AXI3 master; addr_ok same cycle, AR/AW/W from T+1, data_ok comb on R/B.
// Backpressure: addr_ok withheld while AR is pending, a write is active, or limits hit; arbiter per BRIDGE_RR_ARB_EN.
module sram_axi_bridge
    import sram_axi_pkg::*;
#(
    parameter int CH      = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CH-1:0]          req,
    input  logic [CH-1:0]          wr,
    input  logic [2*CH-1:0]        size,
    input  logic [DATA_W/8*CH-1:0] wstrb,
    input  logic [ADDR_W*CH-1:0]   addr,
    input  logic [DATA_W*CH-1:0]   wdata,
    output logic [CH-1:0]          addr_ok,
    output logic [CH-1:0]          data_ok,
    output logic [DATA_W-1:0]      rdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ID_W-1:0]        arid,
    output logic [ADDR_W-1:0]      araddr,
    output logic [2:0]             arsize,
    input  logic                   rvalid,
    input  logic [ID_W-1:0]        rid,
    input  logic [DATA_W-1:0]      rdata_axi,
    output logic                   rready,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [2:0]             awsize,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [DATA_W-1:0]      wdata_axi,
    output logic [DATA_W/8-1:0]    wstrb_axi,
    input  logic                   bvalid,
    output logic                   bready
);

    localparam int CW = cnt_width(MAX_OUT);
    localparam int SW = DATA_W / 8;
    localparam int OW = (CH > 1) ? $clog2(CH) : 1;

    logic [CW-1:0]     rd_cnt_q [CH];
    logic              arvalid_q;
    logic [ID_W-1:0]   arid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [2:0]        arsize_q;

    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [OW-1:0]     own_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [2:0]        awsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]     wstrb_q;

    logic              no_reads;
    logic [CH-1:0]     elig, grant, r_hit;
    logic              b_hit, rd_acc, wr_acc;
    int                sel_idx;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SW-1:0]     sel_wstrb;

    // A write may only start once every read has fully drained, and nothing starts while AR is pending
    always_comb begin
        no_reads = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (rd_cnt_q[c] != '0) no_reads = 1'b0;
        end
        for (int c = 0; c < CH; c++) begin
            elig[c] = req[c] && !arvalid_q && (wr_state_q == WR_IDLE) &&
                      (wr[c] ? no_reads : (rd_cnt_q[c] < CW'(MAX_OUT)));
        end
    end

    bridge_arbiter #(.CH(CH)) u_arb (
        .clk_i   (clk),
        .rst_i   (reset),
        .elig_i  (elig),
        .grant_o (grant)
    );

    assign addr_ok = grant;

    always_comb begin
        sel_idx   = 0;
        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int c = 0; c < CH; c++) begin
            if (grant[c]) begin
                sel_idx   = c;
                sel_wr    = wr[c];
                sel_size  = size[2*c +: 2];
                sel_addr  = addr[ADDR_W*c +: ADDR_W];
                sel_wdata = wdata[DATA_W*c +: DATA_W];
                sel_wstrb = wstrb[SW*c +: SW];
            end
        end
        rd_acc = (grant != '0) && !sel_wr;
        wr_acc = (grant != '0) && sel_wr;
    end

    // Beats for unknown IDs or idle channels are swallowed (rready is tied high)
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            r_hit[c] = rvalid && (rid == ID_W'(c)) && (rd_cnt_q[c] != '0);
        end
        b_hit   = bvalid && (wr_state_q == WR_WAIT_B);
        data_ok = r_hit;
        if (b_hit) data_ok[own_q] = 1'b1;
        rdata = (r_hit != '0) ? rdata_axi : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) rd_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (grant[c] && !wr[c] && !r_hit[c])      rd_cnt_q[c] <= rd_cnt_q[c] + CW'(1);
                else if (r_hit[c] && !(grant[c] && !wr[c])) rd_cnt_q[c] <= rd_cnt_q[c] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
        end else if (rd_acc) begin
            arvalid_q <= 1'b1;
            arid_q    <= ID_W'(sel_idx);
            araddr_q  <= sel_addr;
            arsize_q  <= {1'b0, sel_size};
        end else if (arready) begin
            arvalid_q <= 1'b0;
        end
    end

    assign arvalid = arvalid_q;
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign rready  = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // AW and W complete independently; WAIT_B only once both are done
    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_acc) begin
                    wr_state_d = WR_SEND;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WR_SEND: begin
                aw_done_d = aw_done_q || awready;
                w_done_d  = w_done_q || wready;
                if (aw_done_d && w_done_d) wr_state_d = WR_WAIT_B;
            end
            WR_WAIT_B: begin
                if (bvalid) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        awvalid = (wr_state_q == WR_SEND) && !aw_done_q;
        wvalid  = (wr_state_q == WR_SEND) && !w_done_q;
        bready  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q    <= '0;
            awaddr_q <= '0;
            awsize_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (wr_acc) begin
            own_q    <= OW'(sel_idx);
            awaddr_q <= sel_addr;
            awsize_q <= {1'b0, sel_size};
            wdata_q  <= sel_wdata;
            wstrb_q  <= sel_wstrb;
        end
    end

    assign awaddr    = awaddr_q;
    assign awsize    = awsize_q;
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized bench for sram_axi_bridge against a transaction-level reference model, then a reset scenario.
module tb_sram_axi_bridge;
    import sram_axi_pkg::*;

    localparam int CH = 2, ADDR_W = 32, DATA_W = 32, ID_W = 4, MAX_OUT = 2, SW = 4;

    logic                 clk = 1'b0, reset = 1'b1;
    logic [CH-1:0]        req = '0, wr = '0;
    logic [2*CH-1:0]      size = '0;
    logic [SW*CH-1:0]     wstrb = '0;
    logic [ADDR_W*CH-1:0] addr = '0;
    logic [DATA_W*CH-1:0] wdata = '0;
    logic [CH-1:0]        addr_ok, data_ok;
    logic [DATA_W-1:0]    rdata;
    logic                 arvalid, arready = 1'b0;
    logic [ID_W-1:0]      arid;
    logic [ADDR_W-1:0]    araddr;
    logic [2:0]           arsize;
    logic                 rvalid = 1'b0;
    logic [ID_W-1:0]      rid = '0;
    logic [DATA_W-1:0]    rdata_axi = '0;
    logic                 rready;
    logic                 awvalid, awready = 1'b0;
    logic [ADDR_W-1:0]    awaddr;
    logic [2:0]           awsize;
    logic                 wvalid, wready = 1'b0;
    logic [DATA_W-1:0]    wdata_axi;
    logic [SW-1:0]        wstrb_axi;
    logic                 bvalid = 1'b0, bready;

    sram_axi_bridge #(.CH(CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arsize(arsize),
        .rvalid(rvalid), .rid(rid), .rdata_axi(rdata_axi), .rready(rready),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester side: each channel holds its request until accepted
    bit                p_act [CH];
    bit                p_wr  [CH];
    logic [ADDR_W-1:0] p_addr[CH];
    logic [1:0]        p_size[CH];
    logic [SW-1:0]     p_strb[CH];
    logic [DATA_W-1:0] p_data[CH];

    // Reference model: outstanding reads per channel, pending AR request, write transaction phase
    int                m_out[CH];
    int                issued[CH];
    bit                m_ar_busy;
    int                m_ar_id;
    logic [ADDR_W-1:0] m_ar_addr;
    logic [1:0]        m_ar_size;
    int                m_wph;      // 0 idle, 1 address/data in flight, 2 waiting for response
    bit                m_aw_pend, m_w_pend;
    int                m_own;
    logic [ADDR_W-1:0] m_waddr;
    logic [1:0]        m_wsize;
    logic [DATA_W-1:0] m_wdata;
    logic [SW-1:0]     m_wstrb;
    int                m_ptr;

    task automatic drive_chan();
        for (int c = 0; c < CH; c++) begin
            req[c]                  = p_act[c];
            wr[c]                   = p_wr[c];
            size[2*c +: 2]          = p_size[c];
            addr[ADDR_W*c +: ADDR_W] = p_addr[c];
            wdata[DATA_W*c +: DATA_W] = p_data[c];
            wstrb[SW*c +: SW]       = p_strb[c];
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_arvalid"}, 64'(arvalid), 64'd0);
        check_eq({pfx, "_awvalid"}, 64'(awvalid), 64'd0);
        check_eq({pfx, "_wvalid"},  64'(wvalid),  64'd0);
        check_eq({pfx, "_addr_ok"}, 64'(addr_ok), 64'd0);
        check_eq({pfx, "_data_ok"}, 64'(data_ok), 64'd0);
        check_eq({pfx, "_rdata"},   64'(rdata),   64'd0);
        check_eq({pfx, "_rready"},  64'(rready),  64'd1);
        check_eq({pfx, "_bready"},  64'(bready),  64'd1);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            p_act[c] = 0; p_wr[c] = 0; p_addr[c] = '0; p_size[c] = '0; p_strb[c] = '0; p_data[c] = '0;
            m_out[c] = 0; issued[c] = 0;
        end
        m_ar_busy = 0; m_ar_id = 0; m_ar_addr = '0; m_ar_size = '0;
        m_wph = 0; m_aw_pend = 0; m_w_pend = 0; m_own = 0;
        m_waddr = '0; m_wsize = '0; m_wdata = '0; m_wstrb = '0; m_ptr = 0;

        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1 reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit            el[CH];
            bit            all_zero;
            int            g;
            logic [CH-1:0] exp_ok, exp_dok;
            logic [DATA_W-1:0] exp_rd;
            int            cand;

            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            for (int c = 0; c < CH; c++) begin
                if (!p_act[c] && $urandom_range(0, 2) == 0) begin
                    p_act[c]  = 1;
                    p_wr[c]   = ($urandom_range(0, 3) == 0);
                    p_addr[c] = $urandom & 32'hFFFF_FFFC;
                    p_size[c] = 2'($urandom_range(0, 2));
                    p_strb[c] = 4'($urandom);
                    p_data[c] = $urandom;
                end
            end
            drive_chan();
            arready = ($urandom_range(0, 1) == 1);
            awready = ($urandom_range(0, 2) == 0);
            wready  = ($urandom_range(0, 2) == 0);
            rvalid  = 1'b0;
            rid     = '0;
            rdata_axi = $urandom;
            cand = $urandom_range(0, CH - 1);
            if ($urandom_range(0, 2) == 0 && issued[cand] > 0) begin
                rvalid = 1'b1;
                rid    = ID_W'(cand);
            end else if ($urandom_range(0, 15) == 0) begin
                rvalid = 1'b1;
                rid    = (m_out[cand] == 0) ? ID_W'(cand) : ID_W'($urandom_range(CH, 15));
            end
            bvalid = (m_wph == 2) ? ($urandom_range(0, 1) == 1)
                                  : (m_wph == 0 && $urandom_range(0, 19) == 0);

            @(negedge clk);
            all_zero = 1;
            for (int c = 0; c < CH; c++) if (m_out[c] != 0) all_zero = 0;
            for (int c = 0; c < CH; c++)
                el[c] = p_act[c] && !m_ar_busy && m_wph == 0 &&
                        (p_wr[c] ? all_zero : (m_out[c] < MAX_OUT));
            g = -1;
`ifdef BRIDGE_RR_ARB_EN
            for (int k = 1; k <= CH; k++)
                if (g < 0 && el[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
`else
            for (int c = CH - 1; c >= 0; c--)
                if (g < 0 && el[c]) g = c;
`endif
            exp_ok = '0;
            if (g >= 0) exp_ok[g] = 1'b1;
            exp_dok = '0;
            exp_rd  = '0;
            if (rvalid && int'(rid) < CH && m_out[int'(rid)] > 0) begin
                exp_dok[int'(rid)] = 1'b1;
                exp_rd = rdata_axi;
            end
            if (bvalid && m_wph == 2) exp_dok[m_own] = 1'b1;

            check_eq("addr_ok", 64'(addr_ok), 64'(exp_ok));
            check_eq("data_ok", 64'(data_ok), 64'(exp_dok));
            check_eq("rdata",   64'(rdata),   64'(exp_rd));
            check_eq("arvalid", 64'(arvalid), 64'(m_ar_busy));
            if (m_ar_busy) begin
                check_eq("arid",   64'(arid),   64'(m_ar_id));
                check_eq("araddr", 64'(araddr), 64'(m_ar_addr));
                check_eq("arsize", 64'(arsize), 64'({1'b0, m_ar_size}));
            end
            check_eq("awvalid", 64'(awvalid), 64'(m_wph == 1 && m_aw_pend));
            check_eq("wvalid",  64'(wvalid),  64'(m_wph == 1 && m_w_pend));
            if (m_wph == 1 && m_aw_pend) begin
                check_eq("awaddr", 64'(awaddr), 64'(m_waddr));
                check_eq("awsize", 64'(awsize), 64'({1'b0, m_wsize}));
            end
            if (m_wph == 1 && m_w_pend) begin
                check_eq("wdata", 64'(wdata_axi), 64'(m_wdata));
                check_eq("wstrb", 64'(wstrb_axi), 64'(m_wstrb));
            end

            if (exp_rd != '0 || (rvalid && int'(rid) < CH && m_out[int'(rid)] > 0)) begin
                if (rvalid && int'(rid) < CH && m_out[int'(rid)] > 0) begin
                    m_out[int'(rid)]--;
                    issued[int'(rid)]--;
                end
            end
            if (m_ar_busy && arready) begin
                m_ar_busy = 0;
                issued[m_ar_id]++;
            end
            if (m_wph == 1) begin
                if (awready) m_aw_pend = 0;
                if (wready)  m_w_pend  = 0;
                if (!m_aw_pend && !m_w_pend) m_wph = 2;
            end else if (m_wph == 2 && bvalid) begin
                m_wph = 0;
            end
            if (g >= 0) begin
                p_act[g] = 0;
                m_ptr    = g;
                if (p_wr[g]) begin
                    m_wph = 1; m_aw_pend = 1; m_w_pend = 1; m_own = g;
                    m_waddr = p_addr[g]; m_wsize = p_size[g]; m_wdata = p_data[g]; m_wstrb = p_strb[g];
                end else begin
                    m_out[g]++;
                    m_ar_busy = 1; m_ar_id = g; m_ar_addr = p_addr[g]; m_ar_size = p_size[g];
                end
            end
        end

        // Reset scenario: two reads outstanding, asynchronous reset, stale R beat ignored
        @(posedge clk); #1;
        req = '0; wr = '0; arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst1");
        @(posedge clk); #1;
        reset = 1'b0;
        req = 2'b01; size[1:0] = SIZE_4B; addr[31:0] = 32'h1c00_0000;
        @(negedge clk);
        check_eq("rd0_addr_ok", 64'(addr_ok), 64'd1);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check_eq("rd0_arvalid", 64'(arvalid), 64'd1);
        check_eq("rd0_arid",    64'(arid),    64'd0);
        check_eq("rd0_araddr",  64'(araddr),  64'h1c00_0000);
        @(posedge clk); #1;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        req = 2'b10; wr = '0; size[3:2] = SIZE_4B; addr[63:32] = 32'h0000_2000;
        @(negedge clk);
        check_eq("rd1_addr_ok", 64'(addr_ok), 64'd2);
        @(posedge clk); #1;
        req = '0;
        #3;
        check_eq("pre_rst_arvalid", 64'(arvalid), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("async_arvalid", 64'(arvalid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rvalid = 1'b1; rid = '0; rdata_axi = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("late_r_data_ok", 64'(data_ok), 64'd0);
        check_eq("late_r_rdata",   64'(rdata),   64'd0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        req = 2'b01;
        @(negedge clk);
        check_eq("post_rst_addr_ok", 64'(addr_ok), 64'd1);
        @(posedge clk); #1;
        req = '0;
        rvalid = 1'b1; rid = '0; rdata_axi = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("post_rst_data_ok", 64'(data_ok), 64'd1);
        check_eq("post_rst_rdata",   64'(rdata),   64'hDEAD_BEEF);
        @(posedge clk); #1;
        rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
